// File: rtl/screen_fb_pkg.sv
// Shared constants and helpers for the screen framebuffer.
package screen_pkg;

    localparam int unsigned WORD_D    = 16;
    localparam int unsigned WIDTH_D   = 512;
    localparam int unsigned HEIGHT_D  = 256;
    localparam int unsigned H_BLANK_D = 32;
    localparam int unsigned V_BLANK_D = 8;
    localparam int unsigned ADDR_W_D  = 13;

    // Data bit value that lights a pixel black.
    localparam logic PIX_BLACK = 1'b1;

    function automatic int unsigned words_per_line(input int unsigned width,
                                                   input int unsigned word);
        return width / word;
    endfunction

    localparam int unsigned WORDS = HEIGHT_D * words_per_line(WIDTH_D, WORD_D);

endpackage

// File: rtl/screen_fb_if.sv
// CPU memory port and raster scan-out port of the screen framebuffer.
// SCREEN_FB_INVERT_EN adds the invert control.
interface screen_fb_if import screen_pkg::*; #(
    parameter int unsigned WORD   = WORD_D,
    parameter int unsigned ADDR_W = ADDR_W_D
);
    logic [WORD-1:0]   in;
    logic [WORD-1:0]   out;
    logic              load;
    logic [ADDR_W-1:0] address;
    logic              pix_ce;
    logic              pixel;
    logic              active;
    logic              hsync;
    logic              vsync;
`ifdef SCREEN_FB_INVERT_EN
    logic              invert;

    modport master (output in, load, address, pix_ce, invert,
                    input  out, pixel, active, hsync, vsync);
    modport slave  (input  in, load, address, pix_ce, invert,
                    output out, pixel, active, hsync, vsync);
`else
    modport master (output in, load, address, pix_ce,
                    input  out, pixel, active, hsync, vsync);
    modport slave  (input  in, load, address, pix_ce,
                    output out, pixel, active, hsync, vsync);
`endif
endinterface

// File: rtl/screen_fb_ram.sv
// Dual-port synchronous RAM: port A CPU read/write, port B scan read-only.
// Both ports return the pre-write contents on a same-cycle collision.
module screen_fb_ram #(
    parameter int unsigned WORD  = 16,
    parameter int unsigned DEPTH = 8192,
    parameter int unsigned AW    = 13
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            a_en,
    input  logic            a_we,
    input  logic [AW-1:0]   a_addr,
    input  logic [WORD-1:0] a_din,
    output logic [WORD-1:0] a_dout,
    input  logic            b_en,
    input  logic [AW-1:0]   b_addr,
    output logic [WORD-1:0] b_dout
);
    logic [WORD-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (a_en && a_we) mem[a_addr] <= a_din;
    end

    // Disabled port A reads return zero so out-of-range CPU reads come back as 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     a_dout <= '0;
        else if (a_en) a_dout <= mem[a_addr];
        else           a_dout <= '0;
    end

    always_ff @(posedge clk) begin
        if (b_en) b_dout <= mem[b_addr];
    end
endmodule

// File: rtl/screen_fb.sv
// Memory-mapped screen framebuffer with raster scan-out (Hack screen map).
// Optional feature macro: SCREEN_FB_INVERT_EN (pixel inversion input).
module screen_fb import screen_pkg::*; #(
    parameter int unsigned WORD    = WORD_D,
    parameter int unsigned WIDTH   = WIDTH_D,
    parameter int unsigned HEIGHT  = HEIGHT_D,
    parameter int unsigned H_BLANK = H_BLANK_D,
    parameter int unsigned V_BLANK = V_BLANK_D,
    parameter int unsigned ADDR_W  = ADDR_W_D
) (
    input logic        clk,
    input logic        reset,
    screen_fb_if.slave bus
);
    localparam int unsigned WPL     = words_per_line(WIDTH, WORD);
    localparam int unsigned NWORDS  = HEIGHT * WPL;
    localparam int unsigned AW      = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned H_TOTAL = WIDTH + H_BLANK;
    localparam int unsigned V_TOTAL = HEIGHT + V_BLANK;
    localparam int unsigned XW      = $clog2(H_TOTAL);
    localparam int unsigned YW      = $clog2(V_TOTAL);
    localparam int unsigned BW      = (WORD > 1) ? $clog2(WORD) : 1;

    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic            cpu_en;
    logic            scan_act;
    logic [AW-1:0]   scan_addr;
    logic [WORD-1:0] scan_word;
    logic [WORD-1:0] cpu_word;
    logic            inv;
    logic            act1, hs1, vs1;
    logic [BW-1:0]   bit1;
    logic            pixel_q, active_q, hsync_q, vsync_q;

    assign cpu_en    = 32'(bus.address) < NWORDS;
    assign scan_act  = (32'(x) < WIDTH) && (32'(y) < HEIGHT);
    assign scan_addr = AW'(32'(y) * WPL + 32'(x) / WORD);

`ifdef SCREEN_FB_INVERT_EN
    assign inv = bus.invert;
`else
    assign inv = 1'b0;
`endif

    screen_fb_ram #(.WORD(WORD), .DEPTH(NWORDS), .AW(AW)) u_ram (
        .clk    (clk),
        .reset  (reset),
        .a_en   (cpu_en),
        .a_we   (bus.load),
        .a_addr (AW'(bus.address)),
        .a_din  (bus.in),
        .a_dout (cpu_word),
        .b_en   (bus.pix_ce && scan_act),
        .b_addr (scan_addr),
        .b_dout (scan_word)
    );

    // Raster position counters, advancing once per pixel step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (bus.pix_ce) begin
            if (32'(x) == H_TOTAL - 1) begin
                x <= '0;
                y <= (32'(y) == V_TOTAL - 1) ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    // Stage 1 carries position attributes alongside the RAM fetch; stage 2 picks the bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act1     <= 1'b0;
            hs1      <= 1'b0;
            vs1      <= 1'b0;
            bit1     <= '0;
            pixel_q  <= 1'b0;
            active_q <= 1'b0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
        end else if (bus.pix_ce) begin
            act1     <= scan_act;
            hs1      <= (x == '0);
            vs1      <= (x == '0) && (y == '0);
            bit1     <= BW'(32'(x) % WORD);
            active_q <= act1;
            hsync_q  <= hs1;
            vsync_q  <= vs1;
            pixel_q  <= act1 ? ((scan_word[bit1] ^ inv) ? PIX_BLACK : ~PIX_BLACK)
                             : ~PIX_BLACK;
        end
    end

    assign bus.out    = cpu_word;
    assign bus.pixel  = pixel_q;
    assign bus.active = active_q;
    assign bus.hsync  = hsync_q;
    assign bus.vsync  = vsync_q;
endmodule
